mdu: RTL
========

Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute path.
- Operands come from GRF ReadData1/ReadData2; HI/LO feed the GRF write-data mux for mfhi/mflo.
- Controller drives Start/MDUOp and stalls dependent HI/LO instructions while Busy=1.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >=1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >=1).

Ports:
- clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  launch the operation in MDUOp; sampled only while Busy=0.
- MDUOp  input  3  operation select (encodings in package).
- A  input  32  operand rs.
- B  input  32  operand rt.
- Busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (async assert, any time including mid-operation): HI=0, LO=0, Busy=0, counter=0, latched operands=0. The in-flight result is discarded.
- Ops: MULT (signed 64-bit product), MULTU (unsigned), DIV (signed; LO=quotient truncated toward zero, HI=remainder with the dividend's sign), DIVU (unsigned), MTHI (HI<=A), MTLO (LO<=A). Other encodings are NOP.
- MTHI/MTLO with Start=1 and Busy=0: update at that clock edge; Busy stays 0; the other register is unchanged.
- MULT/MULTU/DIV/DIVU with Start=1 and Busy=0 at edge T0:
  - Latch A, B and op.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); Busy=1 from T0.
  - Counter decrements each edge.
  - At edge T0+N: HI/LO commit the result, Busy=0.
  - A new Start is accepted at that same edge T0+N (back-to-back allowed).
- Start while Busy=1: ignored entirely, including MTHI/MTLO. Operands and op in flight are unaffected.
- Result is computed from the latched operands only; A/B changes during Busy have no effect.
- Divide by zero (B=0, DIV or DIVU): full latency still elapses; HI and LO remain unchanged at completion.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- HI/LO change only at commit edges, MT edges, or Reset. Outputs are registered, with no combinational path from inputs.
- States: IDLE (Busy=0) and RUN (Busy=1, counter>0). IDLE->RUN on accepted mult/div Start; RUN->IDLE when counter reaches 0 (this edge also commits).

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU (signed/unsigned). {HI,LO} <= {HI,LO} ± product, 64-bit wrap, using MULT_CYCLES latency. The accumulator {HI,LO} is sampled at commit.
- Undefined: these encodings decode as NOP (no Busy, no change).

Decomposition:
- Package mdu_pkg: MDUOp width and encodings (NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD/MADDU/MSUB/MSUBU=7 plus one extra bit when MDU_MADD_EN, widening MDUOp to 4).
- Sub-module mdu_calc (combinational): computes the 64-bit {hi,lo} result and a write-valid flag from latched op/A/B (and HI/LO for MADD). The mdu top holds the counter, FSM and registers.

Test Plan:
- MULT A=0xFFFFFFFD, B=7 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 after MTHI 0x11/MTLO 0x22 -> Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- MULT 3*4 started; at cycle 2 pulse MTLO A=0x55 with Start -> ignored; commit gives HI=0, LO=0xC.
- DIVU 100/3 in flight; Reset asserted mid-cycle 4 -> Busy, HI, LO drop to 0 immediately (async). No commit afterwards; a subsequent MULTU 2*3 yields LO=6.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDUOp encodings, FSM state type and decode helpers for the mdu.
// Optional macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU and widens MDUOp to 4 bits.
package mdu_pkg;

`ifdef MDU_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = OP_W'(0),
    OP_MULT  = OP_W'(1),
    OP_MULTU = OP_W'(2),
    OP_DIV   = OP_W'(3),
    OP_DIVU  = OP_W'(4),
    OP_MTHI  = OP_W'(5),
    OP_MTLO  = OP_W'(6)
`ifdef MDU_MADD_EN
    ,
    OP_MADD  = OP_W'(7),
    OP_MADDU = OP_W'(8),
    OP_MSUB  = OP_W'(9),
    OP_MSUBU = OP_W'(10)
`endif
  } mdu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic op_is_long(input mdu_op_e op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_is_long = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_is_long = 1'b1;
`endif
      default: op_is_long = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    case (op)
      OP_DIV, OP_DIVU: op_is_div = 1'b1;
      default:         op_is_div = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Controller-side bus of the mdu: launch request, operands, busy flag and HI/LO.
interface mdu_if;
  import mdu_pkg::*;

  logic            Start;
  logic [OP_W-1:0] MDUOp;
  logic [31:0]     A;
  logic [31:0]     B;
  logic            Busy;
  logic [31:0]     HI;
  logic [31:0]     LO;

  modport master (output Start, MDUOp, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDUOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// Combinational result datapath: 64-bit {hi,lo} and a write-valid flag from latched operands.
// With MDU_MADD_EN the current HI/LO feed the multiply-accumulate ops.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  output logic [63:0] res,
  output logic        wr
);

  logic signed [63:0] smul_s;
  logic [63:0]        umul_s;
  logic [31:0]        ua_s, ub_s, mq_s, mr_s, sq_s, sr_s, uq_s, ur_s;

  // Products and quotients; signed division works on magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    smul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    umul_s = {32'd0, a} * {32'd0, b};
    ua_s   = a[31] ? (32'd0 - a) : a;
    ub_s   = b[31] ? (32'd0 - b) : b;
    mq_s   = 32'd0;
    mr_s   = 32'd0;
    uq_s   = 32'd0;
    ur_s   = 32'd0;
    if (b != 32'd0) begin
      mq_s = ua_s / ub_s;
      mr_s = ua_s % ub_s;
      uq_s = a / b;
      ur_s = a % b;
    end else begin
      mq_s = 32'd0;
      mr_s = 32'd0;
    end
    sq_s = (a[31] ^ b[31]) ? (32'd0 - mq_s) : mq_s;
    sr_s = a[31] ? (32'd0 - mr_s) : mr_s;
  end

  // Result select; divide by zero suppresses the write.
  always_comb begin
    res = 64'd0;
    wr  = 1'b0;
    case (op)
      OP_MULT:  begin res = smul_s;        wr = 1'b1;           end
      OP_MULTU: begin res = umul_s;        wr = 1'b1;           end
      OP_DIV:   begin res = {sr_s, sq_s};  wr = (b != 32'd0);   end
      OP_DIVU:  begin res = {ur_s, uq_s};  wr = (b != 32'd0);   end
`ifdef MDU_MADD_EN
      OP_MADD:  begin res = {hi, lo} + smul_s; wr = 1'b1; end
      OP_MADDU: begin res = {hi, lo} + umul_s; wr = 1'b1; end
      OP_MSUB:  begin res = {hi, lo} - smul_s; wr = 1'b1; end
      OP_MSUBU: begin res = {hi, lo} - umul_s; wr = 1'b1; end
`endif
      default:  begin res = 64'd0; wr = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO; holds the FSM, counter and registers.
// Optional macro MDU_MADD_EN enables the multiply-accumulate ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   Reset,
  mdu_if.slave   bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  mdu_op_e          op_r;
  logic [31:0]      a_r, b_r, hi_r, lo_r;
  logic             busy_r;

  mdu_op_e          op_s;
  logic             open_s, commit_s, launch_s, mthi_s, mtlo_s, wr_s;
  logic [CNT_W-1:0] n_s;
  logic [63:0]      res_s;

  mdu_calc u_calc (
    .op  (op_r),
    .a   (a_r),
    .b   (b_r),
`ifdef MDU_MADD_EN
    .hi  (hi_r),
    .lo  (lo_r),
`endif
    .res (res_s),
    .wr  (wr_s)
  );

  // Start is accepted when idle or on the final busy cycle, so ops can run back to back.
  always_comb begin
    op_s     = mdu_op_e'(bus.MDUOp);
    open_s   = (state_r == ST_IDLE) || (cnt_r == CNT_W'(1));
    commit_s = (state_r == ST_RUN) && (cnt_r == CNT_W'(1));
    launch_s = bus.Start && open_s && op_is_long(op_s);
    mthi_s   = bus.Start && open_s && (op_s == OP_MTHI);
    mtlo_s   = bus.Start && open_s && (op_s == OP_MTLO);
    n_s      = op_is_div(op_s) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  // FSM, latency counter, operand latch and HI/LO; a move issued on a commit edge wins over the result.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      op_r    <= OP_NOP;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      if (commit_s && wr_s) begin
        hi_r <= res_s[63:32];
        lo_r <= res_s[31:0];
      end
      if (mthi_s) hi_r <= bus.A;
      if (mtlo_s) lo_r <= bus.A;
      if (launch_s) begin
        op_r    <= op_s;
        a_r     <= bus.A;
        b_r     <= bus.B;
        cnt_r   <= n_s;
        state_r <= ST_RUN;
        busy_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            cnt_r  <= '0;
            busy_r <= 1'b0;
          end
          ST_RUN: begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (commit_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Busy = busy_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;

endmodule
